// File: rtl/calc_op_sequencer_if.sv
// Request/result handshake bundle for calc_op_sequencer: start/op/a/b/ack in, busy/done/err/result out.
interface calc_op_sequencer_if #(
  parameter int W = 8
);
  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ack;
  logic           busy;
  logic           done;
  logic           err;
  logic [2*W-1:0] result;

  modport master (
    output start, op, a, b, ack,
    input  busy, done, err, result
  );

  modport slave (
    input  start, op, a, b, ack,
    output busy, done, err, result
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Iterative calculator engine: IDLE -> LOAD -> RUN (one step per clock) -> DONE, result held until ack.
// Define CALC_CYCLE_COUNT_EN to add the cycles[15:0] output (RUN cycles of the last completed operation).
module calc_op_sequencer #(
  parameter int W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  calc_op_sequencer_if.slave bus
`ifdef CALC_CYCLE_COUNT_EN
  ,
  output logic [15:0]        cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_DIV     = 3'd2,
    OP_MULT    = 3'd3,
    OP_GCD     = 3'd4,
    OP_ISPRIME = 3'd5,
    OP_SQRT    = 3'd6,
    OP_RSVD    = 3'd7
  } op_t;

  localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TWO_W    = {{(W-2){1'b0}}, 2'b10};
  localparam logic [W:0]   ONE_W1   = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]   TWO_W1   = {{(W-1){1'b0}}, 2'b10};
  localparam logic [W-1:0] MUL_LAST = W'(W - 1);

  state_t state_q, state_n;

  op_t            op_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   x_q, x_n;
  logic [W-1:0]   y_q, y_n;
  logic [W-1:0]   q_q, q_n;
  logic [W:0]     odd_q, odd_n;
  logic [2*W-1:0] mc_q, mc_n;
  logic [2*W-1:0] acc_q, acc_n;
  logic [W-1:0]   cnt_q, cnt_n;

  logic [2*W-1:0] result_q, res_n;
  logic           err_q, err_n;
  logic           fin;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_n = S_LOAD;
      S_LOAD: state_n = S_RUN;
      S_RUN:  if (fin) state_n = S_DONE;
      S_DONE: if (bus.ack) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Shared registers by op: x = remainder/gcd-x/trial remainder, y = divisor/gcd-y/multiplier/trial d,
  // q = quotient/sqrt root, mc/acc = multiply shift-add pair.
  always_comb begin
    x_n   = x_q;
    y_n   = y_q;
    q_n   = q_q;
    odd_n = odd_q;
    mc_n  = mc_q;
    acc_n = acc_q;
    cnt_n = cnt_q;
    res_n = result_q;
    err_n = 1'b0;
    fin   = 1'b0;

    if (state_q == S_LOAD) begin
      x_n   = a_q;
      y_n   = (op_q == OP_ISPRIME) ? TWO_W : b_q;
      q_n   = '0;
      odd_n = ONE_W1;
      mc_n  = {{W{1'b0}}, a_q};
      acc_n = '0;
      cnt_n = '0;
    end else if (state_q == S_RUN) begin
      unique case (op_q)
        OP_ADD: begin
          fin   = 1'b1;
          res_n = {{(W-1){1'b0}}, ({1'b0, a_q} + {1'b0, b_q})};
        end
        OP_SUB: begin
          fin   = 1'b1;
          res_n = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
        end
        OP_DIV: begin
          if (y_q == '0) begin
            fin   = 1'b1;
            err_n = 1'b1;
            res_n = '0;
          end else if (x_q >= y_q) begin
            x_n = x_q - y_q;
            q_n = q_q + ONE_W;
          end else begin
            fin   = 1'b1;
            res_n = {x_q, q_q};
          end
        end
        OP_MULT: begin
          acc_n = acc_q + (y_q[0] ? mc_q : '0);
          mc_n  = mc_q << 1;
          y_n   = y_q >> 1;
          cnt_n = cnt_q + ONE_W;
          res_n = acc_n;
          fin   = (cnt_q == MUL_LAST);
        end
        OP_GCD: begin
          if (x_q == '0) begin
            fin   = 1'b1;
            res_n = {{W{1'b0}}, y_q};
          end else if ((y_q == '0) || (x_q == y_q)) begin
            fin   = 1'b1;
            res_n = {{W{1'b0}}, x_q};
          end else if (x_q > y_q) begin
            x_n = x_q - y_q;
          end else begin
            y_n = y_q - x_q;
          end
        end
        OP_ISPRIME: begin
          // A zero remainder is seen one cycle after the subtract that produced it.
          if (a_q < TWO_W) begin
            fin   = 1'b1;
            res_n = '0;
          end else if (y_q == a_q) begin
            fin   = 1'b1;
            res_n = {{(2*W-1){1'b0}}, 1'b1};
          end else if (x_q == '0) begin
            fin   = 1'b1;
            res_n = '0;
          end else if (x_q < y_q) begin
            y_n = y_q + ONE_W;
            x_n = a_q;
          end else begin
            x_n = x_q - y_q;
          end
        end
        OP_SQRT: begin
          if ({1'b0, x_q} >= odd_q) begin
            x_n   = x_q - odd_q[W-1:0];
            odd_n = odd_q + TWO_W1;
            q_n   = q_q + ONE_W;
          end else begin
            fin   = 1'b1;
            res_n = {{W{1'b0}}, q_q};
          end
        end
        default: begin
          fin   = 1'b1;
          err_n = 1'b1;
          res_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      q_q      <= '0;
      odd_q    <= '0;
      mc_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && bus.start) begin
        op_q <= op_t'(bus.op);
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      x_q   <= x_n;
      y_q   <= y_n;
      q_q   <= q_n;
      odd_q <= odd_n;
      mc_q  <= mc_n;
      acc_q <= acc_n;
      cnt_q <= cnt_n;
      if ((state_q == S_RUN) && fin) begin
        result_q <= res_n;
        err_q    <= err_n;
      end
    end
  end

`ifdef CALC_CYCLE_COUNT_EN
  logic [15:0] run_cnt_q;
  logic [15:0] run_cnt_inc;

  assign run_cnt_inc = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_cnt_q <= '0;
      cycles    <= '0;
    end else if (state_q == S_LOAD) begin
      run_cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      if (fin) cycles    <= run_cnt_inc;
      else     run_cnt_q <= run_cnt_inc;
    end
  end
`endif

  assign bus.busy   = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule
